// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and decode handshake.
// The master side is the fetch stage; the slave side is the surrounding pipeline and memory.
interface if_fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one memory request outstanding,
// and buffers returned words with their PCs in a small FIFO ahead of decode.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_stage_if.master  bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       instr_mem_q [FIFO_DEPTH];
  logic [31:0]       instr_mem_d [FIFO_DEPTH];
  logic [31:0]       pc_mem_q    [FIFO_DEPTH];
  logic [31:0]       pc_mem_d    [FIFO_DEPTH];

  logic req;
  logic accept;
  logic push;
  logic pop;
  logic fifo_valid;

  // Request only with a free slot; a pending redirect suppresses it so no stale address is accepted.
  always_comb begin
    fifo_valid = (count_q != '0);
    req        = rst_n && (state_q == IDLE) && (count_q < DEPTH_C) && !bus.redirect_i;
    accept     = req && bus.imem_ready_i;
    push       = (state_q == WAIT) && bus.imem_rvalid_i && !bus.redirect_i;
    pop        = fifo_valid && !bus.stall_i && !bus.redirect_i;
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = fifo_valid;
  assign bus.instr_o       = fifo_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign bus.pc_o          = fifo_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT:    if (bus.imem_rvalid_i) state_d = IDLE;
      DROP:    if (bus.imem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A response landing with the redirect is consumed here, so only a still-pending one needs DROP.
    if (bus.redirect_i) begin
      fetch_pc_d = bus.redirect_pc_i & ~32'h3;
      if (state_q == WAIT && !bus.imem_rvalid_i) state_d = DROP;
    end
  end

  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    if (bus.redirect_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = bus.imem_rdata_i;
        pc_mem_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

endmodule
